// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared FSM encoding and EX/MEM control-word layout
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int MEMREAD  = 6;
  localparam int MEMWRITE = 5;
  localparam int REGWRITE = 4;
  localparam int MEMTOREG = 3;
  localparam int BUBBLE   = 0;

  localparam logic [6:0] BUBBLE_CTRL = 7'd1;

  function automatic logic is_mem_op(input logic [6:0] ctrl);
    return !ctrl[BUBBLE] && (ctrl[MEMREAD] || ctrl[MEMWRITE]);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_timeout_cnt.sv
// rtl/mem_access_ctrl_timeout_cnt.sv - 8-bit wait counter that flags an access abort
module mem_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [7:0] LIM = LIMIT[7:0];

  logic [7:0] count;

  // Saturates at LIMIT so a stuck access keeps reporting expiry until cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 8'd1;
    end
  end

  assign expire = enable && (count == LIM);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM pipeline stage: data-memory handshake, stall and MEM/WB register
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [6:0]    ctrl_in,
  input  logic [DW-1:0] addr_in,
  input  logic [DW-1:0] wdata_in,
  input  logic [4:0]    regdst_in,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic          stall,
  output logic          wb_valid,
  output logic          wb_regwrite,
  output logic [DW-1:0] wb_data,
  output logic [4:0]    wb_regdst,
  output logic          err_misalign,
  output logic          err_timeout
);

  state_t state, state_nxt;

  logic          op_write, op_regwrite, op_memtoreg;
  logic [DW-1:0] op_addr, op_wdata;
  logic [4:0]    op_regdst;

  logic       evaluate, mem_op, misalign, accept, expire;
  logic [6:0] eff_ctrl;
  logic       unused_ctrl;

  // DONE takes a new op exactly like IDLE; gating with reset keeps stall/req low while held in reset.
  assign evaluate    = reset && (state != ST_ACCESS);
  assign mem_op      = is_mem_op(ctrl_in);
  assign misalign    = mem_op && (addr_in[1:0] != 2'b00);
  assign accept      = evaluate && mem_op && !misalign;
  assign eff_ctrl    = misalign ? BUBBLE_CTRL : ctrl_in;
  assign unused_ctrl = ^ctrl_in[2:1];

  mem_timeout_cnt #(.LIMIT(TIMEOUT)) u_timeout_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (state == ST_ACCESS),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    stall      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_nxt = ST_IDLE;
        if (accept) begin
          dmem_req   = 1'b1;
          dmem_we    = ctrl_in[MEMWRITE];
          dmem_addr  = addr_in;
          dmem_wdata = wdata_in;
          stall      = 1'b1;
          state_nxt  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (expire) begin
          state_nxt = ST_IDLE;
        end else begin
          dmem_req   = 1'b1;
          dmem_we    = op_write;
          dmem_addr  = op_addr;
          dmem_wdata = op_wdata;
          stall      = !dmem_ack;
          if (dmem_ack) state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_write     <= 1'b0;
      op_regwrite  <= 1'b0;
      op_memtoreg  <= 1'b0;
      op_addr      <= '0;
      op_wdata     <= '0;
      op_regdst    <= '0;
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_data      <= '0;
      wb_regdst    <= '0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (misalign) err_misalign <= 1'b1;
          if (accept) begin
            op_write    <= ctrl_in[MEMWRITE];
            op_regwrite <= ctrl_in[REGWRITE];
            op_memtoreg <= ctrl_in[MEMTOREG];
            op_addr     <= addr_in;
            op_wdata    <= wdata_in;
            op_regdst   <= regdst_in;
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
          end else begin
            wb_valid    <= !eff_ctrl[BUBBLE];
            wb_regwrite <= eff_ctrl[REGWRITE] && !eff_ctrl[BUBBLE];
            wb_data     <= addr_in;
            wb_regdst   <= regdst_in;
          end
        end
        ST_ACCESS: begin
          if (expire) begin
            err_timeout <= 1'b1;
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
          end else if (dmem_ack) begin
            wb_valid    <= 1'b1;
            wb_regwrite <= op_regwrite && !op_write;
            wb_data     <= op_memtoreg ? dmem_rdata : op_addr;
            wb_regdst   <= op_regdst;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized bench with a per-operation timeline model of the MEM stage
module tb_mem_access_ctrl;

  localparam int TMO  = 4;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  ctrl_in;
  logic [31:0] addr_in, wdata_in;
  logic [4:0]  regdst_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall, wb_valid, wb_regwrite;
  logic [31:0] wb_data;
  logic [4:0]  wb_regdst;
  logic        err_misalign, err_timeout;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(TMO), .DW(32)) dut (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .regdst_in(regdst_in), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_data(wb_data), .wb_regdst(wb_regdst),
    .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Per-cycle stimulus and expectations, laid out operation by operation.
  logic [6:0]  d_ctrl [MAXC];
  logic [31:0] d_addr [MAXC], d_wdata [MAXC], d_rdata [MAXC];
  logic [4:0]  d_rd   [MAXC];
  logic        d_ack  [MAXC];
  logic        e_req [MAXC], e_we [MAXC], e_stall [MAXC], e_wbv [MAXC], e_wbrw [MAXC];
  logic        e_emis [MAXC], e_eto [MAXC];
  logic [31:0] e_addr [MAXC], e_wdata [MAXC], e_wbd [MAXC];
  logic [4:0]  e_wbrd [MAXC];
  logic        g_req [MAXC], g_stall [MAXC], g_wbv [MAXC], g_wbrw [MAXC], g_emis [MAXC], g_eto [MAXC];
  logic [31:0] g_wbd [MAXC];
  logic [4:0]  g_wbrd [MAXC];
  int          plen = 0;

  logic        m_valid = 1'b0, m_rw = 1'b0, m_mis = 1'b0, m_to = 1'b0;
  logic [31:0] m_data = '0;
  logic [4:0]  m_rd = '0;

  int cur = 0;
  bit checking = 1'b0;

  task automatic chk1(input string nm, input int c, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0d: got %b, want %b", nm, c, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0d: got %h, want %h", nm, c, act, exp);
    end
  endtask

  // delay = cycles the memory leaves an aligned access waiting before ack.
  task automatic add_op(input logic [6:0] ctrl, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input int delay, input logic [31:0] rdata);
    logic mem, wr, mis, timed, last;
    int   len, c;
    mem   = !ctrl[0] && (ctrl[6] || ctrl[5]);
    wr    = ctrl[5];
    mis   = mem && (addr[1:0] != 2'b00);
    timed = mem && !mis && (delay >= TMO);
    if (!mem || mis) len = 1;
    else if (timed)  len = TMO + 2;
    else             len = delay + 2;
    for (int k = 0; k < len; k++) begin
      c    = plen + k;
      last = (k == len - 1);
      d_ctrl[c] = ctrl; d_addr[c] = addr; d_wdata[c] = wdata; d_rd[c] = rd;
      d_rdata[c] = $urandom; d_ack[c] = 1'b0;
      e_wbv[c]  = (k == 0) ? m_valid : 1'b0;
      e_wbrw[c] = m_rw; e_wbd[c] = m_data; e_wbrd[c] = m_rd;
      e_emis[c] = m_mis; e_eto[c] = m_to;
      e_we[c] = wr; e_addr[c] = addr; e_wdata[c] = wdata;
      if (mem && !mis) begin
        e_req[c]   = !(timed && last);
        e_stall[c] = !last;
        if (!timed && last) begin
          d_ack[c] = 1'b1; d_rdata[c] = rdata;
        end else if (k == 0) begin
          d_ack[c] = ($urandom_range(0, 3) == 0);
        end
      end else begin
        e_req[c] = 1'b0; e_stall[c] = 1'b0;
        d_ack[c] = ($urandom_range(0, 3) == 0);
      end
    end
    if (!mem) begin
      m_valid = !ctrl[0]; m_rw = ctrl[4] && !ctrl[0]; m_data = addr; m_rd = rd;
    end else if (mis) begin
      m_mis = 1'b1; m_valid = 1'b0; m_rw = 1'b0;
    end else if (timed) begin
      m_to = 1'b1; m_valid = 1'b0; m_rw = 1'b0;
    end else begin
      m_valid = 1'b1; m_rw = ctrl[4] && !wr; m_data = ctrl[3] ? rdata : addr; m_rd = rd;
    end
    plen += len;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      g_req[cur] = dmem_req; g_stall[cur] = stall; g_wbv[cur] = wb_valid; g_wbrw[cur] = wb_regwrite;
      g_wbd[cur] = wb_data; g_wbrd[cur] = wb_regdst; g_emis[cur] = err_misalign; g_eto[cur] = err_timeout;
      chk1("stall", cur, stall, e_stall[cur]);
      chk1("dmem_req", cur, dmem_req, e_req[cur]);
      if (e_req[cur]) begin
        chk1("dmem_we", cur, dmem_we, e_we[cur]);
        chk32("dmem_addr", cur, dmem_addr, e_addr[cur]);
        chk32("dmem_wdata", cur, dmem_wdata, e_wdata[cur]);
      end
      chk1("wb_valid", cur, wb_valid, e_wbv[cur]);
      if (e_wbv[cur]) begin
        chk1("wb_regwrite", cur, wb_regwrite, e_wbrw[cur]);
        chk32("wb_data", cur, wb_data, e_wbd[cur]);
        chk32("wb_regdst", cur, {27'b0, wb_regdst}, {27'b0, e_wbrd[cur]});
      end
      chk1("err_misalign", cur, err_misalign, e_emis[cur]);
      chk1("err_timeout", cur, err_timeout, e_eto[cur]);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_req"}, 0, dmem_req, 1'b0);
    chk1({tag, "_we"}, 0, dmem_we, 1'b0);
    chk1({tag, "_stall"}, 0, stall, 1'b0);
    chk1({tag, "_wbv"}, 0, wb_valid, 1'b0);
    chk1({tag, "_wbrw"}, 0, wb_regwrite, 1'b0);
    chk32({tag, "_wbd"}, 0, wb_data, 32'h0);
    chk32({tag, "_wbrd"}, 0, {27'b0, wb_regdst}, 32'h0);
    chk1({tag, "_emis"}, 0, err_misalign, 1'b0);
    chk1({tag, "_eto"}, 0, err_timeout, 1'b0);
  endtask

  initial begin
    int s_alu, s_ld, s_st, s_to, s_b2b, rk, rdl, sum;
    logic [6:0]  rc;
    logic [31:0] ra;

    reset = 1'b0; ctrl_in = 7'd1; addr_in = '0; wdata_in = '0; regdst_in = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;

    s_alu = plen; add_op(7'b0010000, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
    s_ld  = plen; add_op(7'b1011000, 32'h100, 32'h0, 5'd7, 3, 32'hCAFEBABE);
    s_st  = plen; add_op(7'b0100000, 32'h103, 32'hDEAD, 5'd0, 0, 32'h0);
    s_to  = plen; add_op(7'b1011000, 32'h200, 32'h0, 5'd8, 10, 32'h0);
    s_b2b = plen; add_op(7'b1011000, 32'h300, 32'h0, 5'd9, 0, 32'h11111111);
                  add_op(7'b1011000, 32'h304, 32'h0, 5'd10, 0, 32'h22222222);
    for (int i = 0; i < 300 && plen < MAXC - 20; i++) begin
      rc = 7'($urandom);
      rk = $urandom_range(0, 9);
      if (rk < 3)      rc[6:5] = 2'b00;
      else if (rk < 6) rc[6:5] = 2'b10;
      else if (rk < 9) rc[6:5] = 2'b01;
      else             rc[6:5] = 2'b11;
      rc[0] = ($urandom_range(0, 9) == 0);
      ra = $urandom;
      ra[1:0] = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rdl = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO, TMO + 3) : $urandom_range(0, TMO - 1);
      add_op(rc, ra, $urandom, 5'($urandom), rdl, $urandom);
    end
    add_op(7'd1, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    add_op(7'd1, 32'h0, 32'h0, 5'd0, 0, 32'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;

    for (int c = 0; c < plen; c++) begin
      @(posedge clk); #1;
      ctrl_in = d_ctrl[c]; addr_in = d_addr[c]; wdata_in = d_wdata[c]; regdst_in = d_rd[c];
      dmem_ack = d_ack[c]; dmem_rdata = d_rdata[c];
      cur = c; checking = 1'b1;
    end
    @(posedge clk); #1;
    checking = 1'b0;
    ctrl_in = 7'd1; dmem_ack = 1'b0;

    // Hand-derived timelines of the directed operations.
    chk1("alu_stall", s_alu, g_stall[s_alu], 1'b0);
    chk1("alu_wbv", s_alu + 1, g_wbv[s_alu + 1], 1'b1);
    chk32("alu_wbd", s_alu + 1, g_wbd[s_alu + 1], 32'h1234);
    chk32("alu_wbrd", s_alu + 1, {27'b0, g_wbrd[s_alu + 1]}, 32'd5);
    sum = 0;
    for (int k = 0; k < 5; k++) sum += int'(g_stall[s_ld + k]);
    chk32("ld_stall_cycles", s_ld, sum, 32'd4);
    chk1("ld_wbv", s_ld + 5, g_wbv[s_ld + 5], 1'b1);
    chk32("ld_wbd", s_ld + 5, g_wbd[s_ld + 5], 32'hCAFEBABE);
    chk1("ld_wbrw", s_ld + 5, g_wbrw[s_ld + 5], 1'b1);
    chk1("st_mis_req", s_st, g_req[s_st], 1'b0);
    chk1("st_mis_err", s_st + 1, g_emis[s_st + 1], 1'b1);
    chk1("st_mis_wbv", s_st + 1, g_wbv[s_st + 1], 1'b0);
    chk1("to_req_last", s_to + 4, g_req[s_to + 4], 1'b1);
    chk1("to_req_drop", s_to + 5, g_req[s_to + 5], 1'b0);
    chk1("to_stall_rel", s_to + 5, g_stall[s_to + 5], 1'b0);
    chk1("to_err", s_to + 6, g_eto[s_to + 6], 1'b1);
    chk1("to_wbv", s_to + 6, g_wbv[s_to + 6], 1'b0);
    chk1("b2b_wbv0", s_b2b + 2, g_wbv[s_b2b + 2], 1'b1);
    chk1("b2b_gap", s_b2b + 3, g_wbv[s_b2b + 3], 1'b0);
    chk1("b2b_wbv1", s_b2b + 4, g_wbv[s_b2b + 4], 1'b1);
    chk32("b2b_wbd1", s_b2b + 4, g_wbd[s_b2b + 4], 32'h22222222);

    // Reset while an access is outstanding.
    @(posedge clk); #1;
    ctrl_in = 7'b1011000; addr_in = 32'h40; regdst_in = 5'd3; dmem_ack = 1'b0;
    @(negedge clk);
    chk1("rst_req_idle", 0, dmem_req, 1'b1);
    @(posedge clk); #2;
    chk1("rst_req_access", 0, dmem_req, 1'b1);
    chk1("rst_stall_access", 0, stall, 1'b1);
    chk1("rst_sticky_mis", 0, err_misalign, 1'b1);
    reset = 1'b0;
    #1;
    chk_all_zero("midrst");
    chk32("midrst_addr", 0, dmem_addr, 32'h0);
    ctrl_in = 7'd1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    ctrl_in = 7'b0010000; addr_in = 32'h55AA; regdst_in = 5'd9;
    @(negedge clk);
    chk1("post_rst_stall", 0, stall, 1'b0);
    chk1("post_rst_req", 0, dmem_req, 1'b0);
    @(posedge clk); #1;
    ctrl_in = 7'd1;
    @(negedge clk);
    chk1("post_rst_wbv", 0, wb_valid, 1'b1);
    chk1("post_rst_wbrw", 0, wb_regwrite, 1'b1);
    chk32("post_rst_wbd", 0, wb_data, 32'h55AA);
    chk32("post_rst_wbrd", 0, {27'b0, wb_regdst}, 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
